obi_sram_shim: RTL

OBI_SRAM_SHIM -- requirements
Module: obi_sram_shim

---
 rtl/obi_sram_shim.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/obi_sram_shim.sv
// OBI subordinate to single-port SRAM adapter.
// Legal beats go to the SRAM in the grant cycle. Out-of-range and atomic
// beats never reach the SRAM and return an error response instead. Responses
// return in order through a fall-through buffer, so a response can appear in
// the cycle after the grant.
module obi_sram_shim #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 8,
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned RspDepth  = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         obi_req_i,
    output logic                         obi_gnt_o,
    input  logic [AddrWidth-1:0]         obi_addr_i,
    input  logic                         obi_we_i,
    input  logic [DataWidth/8-1:0]       obi_be_i,
    input  logic [DataWidth-1:0]         obi_wdata_i,
    input  logic [IdWidth-1:0]           obi_aid_i,
    input  logic [5:0]                   obi_atop_i,
    output logic                         obi_rvalid_o,
    input  logic                         obi_rready_i,
    output logic [DataWidth-1:0]         obi_rdata_o,
    output logic [IdWidth-1:0]           obi_rid_o,
    output logic                         obi_err_o,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [$clog2(NumWords)-1:0]  sram_addr_o,
    output logic [DataWidth/8-1:0]       sram_be_o,
    output logic [DataWidth-1:0]         sram_wdata_o,
    input  logic [DataWidth-1:0]         sram_rdata_i
);

    localparam int unsigned ByteOffW = $clog2(DataWidth/8);
    localparam int unsigned SramAW   = $clog2(NumWords);
    localparam int unsigned CntWidth = $clog2(RspDepth + 1);
    localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    logic [AddrWidth-1:0] word_idx;
    logic                 in_range;
    logic                 legal;
    logic [CntWidth:0]    occupancy;
    logic                 accept;

    logic [CntWidth-1:0]  count_q, count_d;
    logic [PtrWidth-1:0]  wptr_q, wptr_d;
    logic [PtrWidth-1:0]  rptr_q, rptr_d;
    logic                 pending_q;
    logic [IdWidth-1:0]   id_q, id_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;

    logic [DataWidth-1:0] buf_rdata_q [RspDepth];
    logic [IdWidth-1:0]   buf_rid_q   [RspDepth];
    logic                 buf_err_q   [RspDepth];

    logic [DataWidth-1:0] push_rdata;
    logic                 fifo_empty;
    logic                 pop;
    logic                 store;
    logic                 drop;

    assign word_idx  = obi_addr_i >> ByteOffW;
    assign in_range  = word_idx < AddrWidth'(NumWords);
    assign legal     = in_range && (obi_atop_i == 6'd0);
    // The pending beat is counted so the buffer always has room for it.
    assign occupancy = {1'b0, count_q} + {{CntWidth{1'b0}}, pending_q};
    assign obi_gnt_o = rst_ni && obi_req_i && (occupancy < (CntWidth + 1)'(RspDepth));
    assign accept    = obi_gnt_o;

    assign sram_req_o   = accept && legal;
    assign sram_we_o    = obi_we_i;
    assign sram_addr_o  = word_idx[SramAW-1:0];
    assign sram_be_o    = obi_be_i;
    assign sram_wdata_o = obi_wdata_i;

    // Only a legal read carries SRAM data back; writes and errors return zero.
    assign push_rdata   = (!we_q && !err_q) ? sram_rdata_i : '0;
    assign fifo_empty   = (count_q == '0);
    assign obi_rvalid_o = !fifo_empty || pending_q;
    assign pop          = obi_rvalid_o && obi_rready_i;
    // A response consumed while bypassing an empty buffer is never stored.
    assign store        = pending_q && !(fifo_empty && pop);
    assign drop         = pop && !fifo_empty;

    // Response payload: buffer head, else the bypassed entry, else zero.
    always_comb begin
        obi_rdata_o = '0;
        obi_rid_o   = '0;
        obi_err_o   = 1'b0;
        if (!fifo_empty) begin
            obi_rdata_o = buf_rdata_q[rptr_q];
            obi_rid_o   = buf_rid_q[rptr_q];
            obi_err_o   = buf_err_q[rptr_q];
        end else if (pending_q) begin
            obi_rdata_o = push_rdata;
            obi_rid_o   = id_q;
            obi_err_o   = err_q;
        end
    end

    // Next-state for occupancy, pointers and the accepted-beat attributes.
    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        id_d    = id_q;
        we_d    = we_q;
        err_d   = err_q;
        if (store && !drop) begin
            count_d = count_q + CntWidth'(1);
        end else if (!store && drop) begin
            count_d = count_q - CntWidth'(1);
        end
        if (store) begin
            wptr_d = (wptr_q == PtrWidth'(RspDepth - 1)) ? '0 : wptr_q + PtrWidth'(1);
        end
        if (drop) begin
            rptr_d = (rptr_q == PtrWidth'(RspDepth - 1)) ? '0 : rptr_q + PtrWidth'(1);
        end
        if (accept) begin
            id_d  = obi_aid_i;
            we_d  = obi_we_i;
            err_d = !legal;
        end
    end

    // Control state; reset discards all in-flight and buffered responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            pending_q <= 1'b0;
            id_q      <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            pending_q <= accept;
            id_q      <= id_d;
            we_q      <= we_d;
            err_q     <= err_d;
        end
    end

    // Response storage; contents are only visible while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (store) begin
            buf_rdata_q[wptr_q] <= push_rdata;
            buf_rid_q[wptr_q]   <= id_q;
            buf_err_q[wptr_q]   <= err_q;
        end
    end

endmodule
